// File: rtl/demo_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demo_seq_pkg
// Description : Shared definitions for the demo traffic sequencer: operation
//               mode encodings, the per-channel state type and the pattern
//               stride applied between channels.
// Revision    : 1.0 - initial release
// ============================================================================
package demo_seq_pkg;

    // Operation modes as presented on the mode input. 2'b11 is decoded by
    // the top level as an alias of MODE_WRV.
    localparam logic [1:0] MODE_WR  = 2'b00;
    localparam logic [1:0] MODE_RD  = 2'b01;
    localparam logic [1:0] MODE_WRV = 2'b10;

    // Data pattern offset between neighbouring channels.
    localparam int CH_STRIDE = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FIN     = 3'd4
    } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/demo_seq_ch.sv
`default_nettype none
// ============================================================================
// Module      : demo_seq_ch
// Description : One traffic channel. Issues BURST_LEN write and/or read
//               requests of a deterministic pattern, checks returned read
//               data and raises a one-cycle err pulse per failed beat
//               (data mismatch or read timeout).
// Ports       : clk, rstn           clock, async active-low reset
//               go, go_write        start this channel; first phase is write
//               verify              after writes, read the burst back
//               fin_release         all enabled channels done, leave FIN
//               slave_sel, seed     latched operation parameters
//               idle, at_fin, err   status to the top level
//               d_*                 device-side request interface
// Revision    : 1.0 - initial release
// ============================================================================
module demo_seq_ch
    import demo_seq_pkg::*;
#(
    parameter int CH_IDX               = 0,
    parameter int ADDR_WIDTH           = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12,
    parameter int BURST_LEN            = 4,
    parameter int TIMEOUT              = 64
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        go,
    input  logic                                        go_write,
    input  logic                                        verify,
    input  logic                                        fin_release,
    input  logic [ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH-1:0]  slave_sel,
    input  logic [DATA_WIDTH-1:0]                       seed,
    output logic                                        idle,
    output logic                                        at_fin,
    output logic                                        err,
    output logic                                        d_valid,
    output logic                                        d_mode,
    output logic [ADDR_WIDTH-1:0]                       d_addr,
    output logic [DATA_WIDTH-1:0]                       d_wdata,
    input  logic                                        d_ready,
    input  logic                                        d_rvalid,
    input  logic [DATA_WIDTH-1:0]                       d_rdata
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [BEAT_W-1:0]               C_LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [TMO_W-1:0]                C_TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [SLAVE_MEM_ADDR_WIDTH-1:0] C_OFF_BASE  = SLAVE_MEM_ADDR_WIDTH'(CH_IDX * BURST_LEN);
    localparam logic [DATA_WIDTH-1:0]           C_DATA_BASE = DATA_WIDTH'(CH_IDX * CH_STRIDE);

    ch_state_t                       r_state;
    ch_state_t                       w_next;
    logic [BEAT_W-1:0]               r_beat;
    logic [TMO_W-1:0]                r_tmo;
    logic                            w_last;
    logic                            w_timeout;
    logic                            w_beat_done;
    logic [SLAVE_MEM_ADDR_WIDTH-1:0] w_off;
    logic [DATA_WIDTH-1:0]           w_pattern;

    assign w_last    = (r_beat == C_LAST_BEAT);
    // r_tmo is 0 in the first RD_WAIT cycle, so the beat gives up after
    // exactly TIMEOUT cycles without read data.
    assign w_timeout = (r_tmo == C_TMO_LAST);
    // Truncating adds give the modulo wrap of offset and data for free.
    assign w_off     = C_OFF_BASE + SLAVE_MEM_ADDR_WIDTH'(r_beat);
    assign w_pattern = seed + C_DATA_BASE + DATA_WIDTH'(r_beat);

    assign w_beat_done = ((r_state == ST_WR_REQ) && d_ready) ||
                         ((r_state == ST_RD_WAIT) && (d_rvalid || w_timeout));

    assign idle    = (r_state == ST_IDLE);
    assign at_fin  = (r_state == ST_FIN);
    assign d_addr  = d_valid ? {slave_sel, w_off} : '0;
    assign d_wdata = d_mode ? w_pattern : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        d_valid = 1'b0;
        d_mode  = 1'b0;
        err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_next = go_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                d_valid = 1'b1;
                d_mode  = 1'b1;
                if (d_ready && w_last) begin
                    w_next = verify ? ST_RD_REQ : ST_FIN;
                end
            end
            ST_RD_REQ: begin
                d_valid = 1'b1;
                if (d_ready) begin
                    w_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // Read data wins over a coincident timeout.
                if (d_rvalid || w_timeout) begin
                    err    = d_rvalid ? (d_rdata != w_pattern) : 1'b1;
                    w_next = w_last ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_FIN: begin
                if (fin_release) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Beat index restarts at 0 after the last write so the verify pass
    // reads the same addresses back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat <= '0;
            r_tmo  <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_beat <= '0;
            end else if (w_beat_done) begin
                r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
            end
            r_tmo <= (r_state == ST_RD_WAIT) ? r_tmo + TMO_W'(1) : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/demo_seq.sv
`default_nettype none
// ============================================================================
// Module      : demo_seq
// Description : Parametrised demo traffic sequencer. NUM_CH independent
//               channels each drive one bus master with write, read-verify
//               or write-then-verify bursts; the top level latches the
//               operation, synchronises channel completion, generates done
//               and accumulates a saturating error count.
// Ports       : clk, rstn                     clock, async active-low reset
//               start, mode, ch_en,
//               slave_sel, seed               operation request/parameters
//               ch_ready, busy, done,
//               err_count                     status
//               d_valid, d_mode, d_addr,
//               d_wdata, d_ready, d_rvalid,
//               d_rdata                       per-channel request interfaces
// Revision    : 1.0 - initial release
// ============================================================================
module demo_seq
    import demo_seq_pkg::*;
#(
    parameter int NUM_CH               = 2,
    parameter int ADDR_WIDTH           = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12,
    parameter int BURST_LEN            = 4,
    parameter int TIMEOUT              = 64,
    parameter int ERR_WIDTH            = 8
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        start,
    input  logic [1:0]                                  mode,
    input  logic [NUM_CH-1:0]                           ch_en,
    input  logic [ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH-1:0]  slave_sel,
    input  logic [DATA_WIDTH-1:0]                       seed,
    output logic [NUM_CH-1:0]                           ch_ready,
    output logic                                        busy,
    output logic                                        done,
    output logic [ERR_WIDTH-1:0]                        err_count,
    output logic [NUM_CH-1:0]                           d_valid,
    output logic [NUM_CH-1:0]                           d_mode,
    output logic [NUM_CH*ADDR_WIDTH-1:0]                d_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0]                d_wdata,
    input  logic [NUM_CH-1:0]                           d_ready,
    input  logic [NUM_CH-1:0]                           d_rvalid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                d_rdata
);

    localparam int SEL_W = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int SUM_W = ERR_WIDTH + CNT_W;
    localparam logic [ERR_WIDTH-1:0] C_ERR_MAX = {ERR_WIDTH{1'b1}};

    logic [NUM_CH-1:0]    w_idle;
    logic [NUM_CH-1:0]    w_fin;
    logic [NUM_CH-1:0]    w_err;
    logic [NUM_CH-1:0]    w_go;
    logic                 w_accept;
    logic                 w_go_write;
    logic                 w_all_fin;
    logic [CNT_W-1:0]     w_nerr;
    logic [SUM_W-1:0]     w_sum;
    logic [ERR_WIDTH-1:0] w_err_next;

    logic                 r_verify;
    logic [NUM_CH-1:0]    r_en;
    logic [SEL_W-1:0]     r_sel;
    logic [DATA_WIDTH-1:0] r_seed;
    logic                 r_done;
    logic [ERR_WIDTH-1:0] r_err;

    assign busy      = ~&w_idle;
    assign ch_ready  = w_idle;
    assign done      = r_done;
    assign err_count = r_err;

    assign w_accept   = start && !busy;
    assign w_go       = {NUM_CH{w_accept}} & ch_en;
    assign w_go_write = (mode != MODE_RD);

    // Barrier: every channel of the current operation sits in FIN. Once the
    // channels are released they read IDLE, so this cannot re-fire.
    assign w_all_fin = (r_en != '0) && (&(w_fin | ~r_en));

    // Saturating accumulation of all per-channel error pulses this cycle.
    always_comb begin
        w_nerr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_nerr = w_nerr + CNT_W'(w_err[i]);
        end
        w_sum      = SUM_W'(r_err) + SUM_W'(w_nerr);
        w_err_next = (w_sum > SUM_W'(C_ERR_MAX)) ? C_ERR_MAX : w_sum[ERR_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_verify <= 1'b0;
            r_en     <= '0;
            r_sel    <= '0;
            r_seed   <= '0;
            r_done   <= 1'b0;
            r_err    <= '0;
        end else begin
            // An empty channel set still completes, one cycle after start.
            r_done <= w_all_fin || (w_accept && (ch_en == '0));
            if (w_accept) begin
                // 2'b11 is handled as write-then-verify.
                r_verify <= (mode == MODE_WRV) || (mode == (MODE_WRV | MODE_RD));
                r_en     <= ch_en;
                r_sel    <= slave_sel;
                r_seed   <= seed;
                r_err    <= '0;
            end else begin
                r_err    <= w_err_next;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        demo_seq_ch #(
            .CH_IDX               (c),
            .ADDR_WIDTH           (ADDR_WIDTH),
            .DATA_WIDTH           (DATA_WIDTH),
            .SLAVE_MEM_ADDR_WIDTH (SLAVE_MEM_ADDR_WIDTH),
            .BURST_LEN            (BURST_LEN),
            .TIMEOUT              (TIMEOUT)
        ) u_ch (
            .clk         (clk),
            .rstn        (rstn),
            .go          (w_go[c]),
            .go_write    (w_go_write),
            .verify      (r_verify),
            .fin_release (w_all_fin),
            .slave_sel   (r_sel),
            .seed        (r_seed),
            .idle        (w_idle[c]),
            .at_fin      (w_fin[c]),
            .err         (w_err[c]),
            .d_valid     (d_valid[c]),
            .d_mode      (d_mode[c]),
            .d_addr      (d_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .d_wdata     (d_wdata[c*DATA_WIDTH +: DATA_WIDTH]),
            .d_ready     (d_ready[c]),
            .d_rvalid    (d_rvalid[c]),
            .d_rdata     (d_rdata[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_demo_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_demo_seq
// Description : Directed self-checking bench for demo_seq with a responsive
//               slave memory model (random stalls, corrupted and dropped
//               read responses on request).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demo_seq;

    localparam int NUM_CH               = 2;
    localparam int ADDR_WIDTH           = 16;
    localparam int DATA_WIDTH           = 8;
    localparam int SLAVE_MEM_ADDR_WIDTH = 12;
    localparam int BURST_LEN            = 4;
    localparam int TIMEOUT              = 64;
    localparam int ERR_WIDTH            = 8;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  ch_en;
    logic [3:0]  slave_sel;
    logic [7:0]  seed;
    logic [1:0]  ch_ready;
    logic        busy;
    logic        done;
    logic [7:0]  err_count;
    logic [1:0]  d_valid;
    logic [1:0]  d_mode;
    logic [31:0] d_addr;
    logic [15:0] d_wdata;
    logic [1:0]  d_ready;
    logic [1:0]  d_rvalid;
    logic [15:0] d_rdata;

    demo_seq #(
        .NUM_CH               (NUM_CH),
        .ADDR_WIDTH           (ADDR_WIDTH),
        .DATA_WIDTH           (DATA_WIDTH),
        .SLAVE_MEM_ADDR_WIDTH (SLAVE_MEM_ADDR_WIDTH),
        .BURST_LEN            (BURST_LEN),
        .TIMEOUT              (TIMEOUT),
        .ERR_WIDTH            (ERR_WIDTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .mode      (mode),
        .ch_en     (ch_en),
        .slave_sel (slave_sel),
        .seed      (seed),
        .ch_ready  (ch_ready),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .d_valid   (d_valid),
        .d_mode    (d_mode),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory / responder model state
    logic [7:0]  mem [int];
    int          wr_cnt [2];
    int          rd_cnt [2];
    bit          rd_pend [2];
    logic [15:0] pend_addr [2];
    int          pend_beat [2];
    bit          prev_stall [2];
    logic        prev_mode [2];
    logic [15:0] prev_addr [2];
    logic [7:0]  prev_wdata [2];
    logic [3:0]  cur_sel;
    logic [7:0]  cur_seed;
    int          stall_pct = 0;
    bit          corrupt_en = 0;
    bit          drop_en = 0;
    int          done_cnt;
    bit          busy_seen;
    bit          done_now;
    bit          gap_active;
    bit          gap_done;
    int          gap;
    logic [1:0]  first_valid;
    logic        first_busy;
    logic        done_busy;
    logic [1:0]  done_ready;
    logic [7:0]  done_err;

    function automatic logic [7:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            wr_cnt[c] = 0; rd_cnt[c] = 0; rd_pend[c] = 0; prev_stall[c] = 0;
        end
        d_rvalid = '0;
        done_cnt = 0; busy_seen = 0;
        gap_active = 0; gap_done = 0; gap = 0;
    endtask

    // One clock cycle: sample at negedge, then drive the responder inputs
    // for the following posedge and record the handshakes that will occur.
    task automatic step();
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        logic [7:0]  rd;
        @(negedge clk);
        done_now = (done === 1'b1);
        if (done_now) done_cnt++;
        if (busy === 1'b1) busy_seen = 1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (prev_stall[c]) begin
                total++;
                if (d_valid[c] !== 1'b1 || d_mode[c] !== prev_mode[c] ||
                    d_addr[c*16 +: 16] !== prev_addr[c] || d_wdata[c*8 +: 8] !== prev_wdata[c]) begin
                    bad++;
                    $display("FAIL stall_stable ch%0d: valid=%b mode=%b addr=%h wdata=%h, required 1 %b %h %h",
                             c, d_valid[c], d_mode[c], d_addr[c*16 +: 16], d_wdata[c*8 +: 8],
                             prev_mode[c], prev_addr[c], prev_wdata[c]);
                end
            end
        end
        if (gap_active) begin
            if (d_valid[1] === 1'b1) begin gap_active = 0; gap_done = 1; end
            else gap++;
        end
        d_rvalid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_pend[c]) begin
                rd = mem_rd(int'(pend_addr[c]));
                if (corrupt_en && c == 0 && pend_beat[c] == 2) rd = rd ^ 8'hFF;
                d_rvalid[c] = 1'b1;
                d_rdata[c*8 +: 8] = rd;
                rd_pend[c] = 0;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            d_ready[c] = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (d_valid[c] === 1'b1 && d_ready[c] === 1'b1) begin
                if (d_mode[c]) begin
                    exp_a = {cur_sel, 12'(c*BURST_LEN + wr_cnt[c])};
                    exp_d = 8'(int'(cur_seed) + c*16 + wr_cnt[c]);
                    total++;
                    if (d_addr[c*16 +: 16] !== exp_a || d_wdata[c*8 +: 8] !== exp_d) begin
                        bad++;
                        $display("FAIL wr_beat ch%0d beat%0d: addr=%h data=%h, required addr=%h data=%h",
                                 c, wr_cnt[c], d_addr[c*16 +: 16], d_wdata[c*8 +: 8], exp_a, exp_d);
                    end
                    mem[int'(d_addr[c*16 +: 16])] = d_wdata[c*8 +: 8];
                    wr_cnt[c]++;
                end else begin
                    exp_a = {cur_sel, 12'(c*BURST_LEN + rd_cnt[c])};
                    total++;
                    if (d_addr[c*16 +: 16] !== exp_a) begin
                        bad++;
                        $display("FAIL rd_beat ch%0d beat%0d: addr=%h, required %h",
                                 c, rd_cnt[c], d_addr[c*16 +: 16], exp_a);
                    end
                    if (drop_en && c == 1 && rd_cnt[c] == 0) begin
                        gap_active = 1; gap = 0;
                    end else begin
                        rd_pend[c] = 1; pend_addr[c] = d_addr[c*16 +: 16]; pend_beat[c] = rd_cnt[c];
                    end
                    rd_cnt[c]++;
                end
            end
            prev_stall[c] = (d_valid[c] === 1'b1) && (d_ready[c] !== 1'b1);
            prev_mode[c]  = d_mode[c];
            prev_addr[c]  = d_addr[c*16 +: 16];
            prev_wdata[c] = d_wdata[c*8 +: 8];
        end
    endtask

    task automatic launch(input logic [1:0] m, input logic [1:0] en,
                          input logic [3:0] sel, input logic [7:0] sd);
        step();
        model_clear();
        cur_sel = sel; cur_seed = sd;
        mode = m; ch_en = en; slave_sel = sel; seed = sd; start = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < max_cyc) begin
            step(); start = 1'b0; n++;
            if (n == 1) begin first_valid = d_valid; first_busy = busy; end
            if (done_now) begin
                seen = 1; done_busy = busy; done_ready = ch_ready; done_err = err_count;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_wait: no done after %0d cycles, required within %0d", n, max_cyc);
        end
        step(); step();
    endtask

    task automatic test_reset();
        bit idle_bad;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ch_ready !== 2'b11) begin bad++; $display("FAIL rst_ch_ready: got %b required 11", ch_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", done); end
        total++; if (err_count !== 8'h00) begin bad++; $display("FAIL rst_err: got %h required 00", err_count); end
        total++; if (d_valid !== 2'b00 || d_mode !== 2'b00) begin bad++; $display("FAIL rst_valid_mode: got %b %b required 00 00", d_valid, d_mode); end
        total++; if (d_addr !== 32'h0 || d_wdata !== 16'h0) begin bad++; $display("FAIL rst_addr_data: got %h %h required 0 0", d_addr, d_wdata); end
        rstn = 1'b1;
        model_clear();
        idle_bad = 0;
        repeat (20) begin
            step();
            if (d_valid !== 2'b00 || busy !== 1'b0 || ch_ready !== 2'b11 || done !== 1'b0) idle_bad = 1;
        end
        total++;
        if (idle_bad) begin bad++; $display("FAIL idle_20: activity seen while idle, required none"); end
    endtask

    task automatic test_wrv_single();
        int n;
        stall_pct = 0;
        launch(2'b10, 2'b01, 4'h1, 8'h10);
        wait_done(60, n);
        total++; if (first_valid !== 2'b01 || first_busy !== 1'b1) begin bad++; $display("FAIL wrv_first: valid=%b busy=%b required 01 1", first_valid, first_busy); end
        total++; if (wr_cnt[0] != 4 || rd_cnt[0] != 4 || wr_cnt[1] != 0 || rd_cnt[1] != 0) begin bad++; $display("FAIL wrv_counts: wr=%0d/%0d rd=%0d/%0d required 4/0 4/0", wr_cnt[0], wr_cnt[1], rd_cnt[0], rd_cnt[1]); end
        total++; if (mem_rd(32'h1000) !== 8'h10 || mem_rd(32'h1003) !== 8'h13) begin bad++; $display("FAIL wrv_mem: %h %h required 10 13", mem_rd(32'h1000), mem_rd(32'h1003)); end
        total++; if (n != 14) begin bad++; $display("FAIL wrv_latency: got %0d required 14", n); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL wrv_done_cnt: got %0d required 1", done_cnt); end
        total++; if (done_err !== 8'h00) begin bad++; $display("FAIL wrv_err: got %h required 00", done_err); end
        total++; if (done_busy !== 1'b0 || done_ready !== 2'b11) begin bad++; $display("FAIL wrv_done_status: busy=%b ready=%b required 0 11", done_busy, done_ready); end
    endtask

    task automatic test_write_latency();
        int n;
        launch(2'b00, 2'b01, 4'h6, 8'h05);
        wait_done(40, n);
        total++; if (n != BURST_LEN + 2) begin bad++; $display("FAIL wr_latency: got %0d required %0d", n, BURST_LEN + 2); end
        total++; if (wr_cnt[0] != 4 || rd_cnt[0] != 0) begin bad++; $display("FAIL wr_counts: wr=%0d rd=%0d required 4 0", wr_cnt[0], rd_cnt[0]); end
    endtask

    task automatic test_stall_two_ch();
        int n;
        stall_pct = 40;
        launch(2'b10, 2'b11, 4'h3, 8'h20);
        wait_done(400, n);
        stall_pct = 0;
        total++; if (first_valid !== 2'b11) begin bad++; $display("FAIL stall_first: valid=%b required 11", first_valid); end
        total++; if (wr_cnt[0] != 4 || wr_cnt[1] != 4 || rd_cnt[0] != 4 || rd_cnt[1] != 4) begin bad++; $display("FAIL stall_counts: wr=%0d/%0d rd=%0d/%0d required 4/4 4/4", wr_cnt[0], wr_cnt[1], rd_cnt[0], rd_cnt[1]); end
        total++; if (mem_rd(32'h3004) !== 8'h30 || mem_rd(32'h3007) !== 8'h33) begin bad++; $display("FAIL stall_mem_ch1: %h %h required 30 33", mem_rd(32'h3004), mem_rd(32'h3007)); end
        total++; if (done_cnt != 1 || done_err !== 8'h00) begin bad++; $display("FAIL stall_done: cnt=%0d err=%h required 1 00", done_cnt, done_err); end
    endtask

    task automatic test_read_verify_errors();
        int n;
        for (int b = 0; b < 4; b++) begin
            mem[32'h2000 + b] = 8'(8'h40 + b);
            mem[32'h2004 + b] = 8'(8'h50 + b);
        end
        corrupt_en = 1; drop_en = 1;
        launch(2'b01, 2'b11, 4'h2, 8'h40);
        wait_done(400, n);
        corrupt_en = 0; drop_en = 0;
        total++; if (done_err !== 8'h02) begin bad++; $display("FAIL rderr_count: got %h required 02", done_err); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL rderr_done_cnt: got %0d required 1", done_cnt); end
        total++; if (!gap_done || gap < TIMEOUT || gap > TIMEOUT + 1) begin bad++; $display("FAIL rderr_timeout_gap: got %0d (ended=%0d) required %0d..%0d", gap, gap_done, TIMEOUT, TIMEOUT + 1); end
        total++; if (wr_cnt[0] != 0 || wr_cnt[1] != 0 || rd_cnt[0] != 4 || rd_cnt[1] != 4) begin bad++; $display("FAIL rderr_counts: wr=%0d/%0d rd=%0d/%0d required 0/0 4/4", wr_cnt[0], wr_cnt[1], rd_cnt[0], rd_cnt[1]); end
    endtask

    task automatic test_start_busy_and_empty();
        int n;
        launch(2'b00, 2'b01, 4'h4, 8'h60);
        step(); start = 1'b0;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid_op: got %b required 1", busy); end
        mode = 2'b01; ch_en = 2'b11; seed = 8'hAA; slave_sel = 4'h9; start = 1'b1;
        step(); start = 1'b0;
        wait_done(40, n);
        total++; if (wr_cnt[0] != 4 || wr_cnt[1] != 0 || rd_cnt[0] != 0 || rd_cnt[1] != 0) begin bad++; $display("FAIL busy_start_ignored: wr=%0d/%0d rd=%0d/%0d required 4/0 0/0", wr_cnt[0], wr_cnt[1], rd_cnt[0], rd_cnt[1]); end
        total++; if (done_cnt != 1 || done_err !== 8'h00) begin bad++; $display("FAIL busy_done: cnt=%0d err=%h required 1 00", done_cnt, done_err); end
        launch(2'b00, 2'b00, 4'h4, 8'h61);
        wait_done(10, n);
        total++; if (n != 1) begin bad++; $display("FAIL empty_latency: got %0d required 1", n); end
        total++; if (busy_seen || first_valid !== 2'b00) begin bad++; $display("FAIL empty_busy: busy_seen=%0d valid=%b required 0 00", busy_seen, first_valid); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL empty_done_cnt: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        launch(2'b10, 2'b11, 4'h5, 8'h70);
        repeat (3) begin step(); start = 1'b0; end
        rstn = 1'b0;
        model_clear();
        #1;
        total++; if (d_valid !== 2'b00 || busy !== 1'b0 || ch_ready !== 2'b11) begin bad++; $display("FAIL midrst_status: valid=%b busy=%b ready=%b required 00 0 11", d_valid, busy, ch_ready); end
        total++; if (d_addr !== 32'h0 || d_wdata !== 16'h0 || d_mode !== 2'b00 || err_count !== 8'h00) begin bad++; $display("FAIL midrst_outputs: addr=%h wdata=%h mode=%b err=%h required 0", d_addr, d_wdata, d_mode, err_count); end
        repeat (3) step();
        total++; if (done_cnt != 0) begin bad++; $display("FAIL midrst_done: got %0d pulses required 0", done_cnt); end
        rstn = 1'b1;
        launch(2'b10, 2'b11, 4'h5, 8'h70);
        wait_done(60, n);
        total++; if (wr_cnt[0] != 4 || wr_cnt[1] != 4 || rd_cnt[0] != 4 || rd_cnt[1] != 4) begin bad++; $display("FAIL midrst_rerun_counts: wr=%0d/%0d rd=%0d/%0d required 4/4 4/4", wr_cnt[0], wr_cnt[1], rd_cnt[0], rd_cnt[1]); end
        total++; if (done_cnt != 1 || done_err !== 8'h00) begin bad++; $display("FAIL midrst_rerun_done: cnt=%0d err=%h required 1 00", done_cnt, done_err); end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; mode = 2'b00; ch_en = 2'b00;
        slave_sel = 4'h0; seed = 8'h00;
        d_ready = 2'b00; d_rvalid = 2'b00; d_rdata = 16'h0;
        cur_sel = 4'h0; cur_seed = 8'h00;
        model_clear();
        test_reset();
        test_wrv_single();
        test_write_latency();
        test_stall_two_ch();
        test_read_verify_errors();
        test_start_busy_and_empty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demo_seq.md
# demo_seq

Parametrised demo traffic sequencer for the system-bus demo top. It replaces the fixed two-device, single-beat demo stimulus with NUM_CH independent channels. Each channel drives one bus master's device-side request interface with multi-beat write, read, or write-then-verify bursts of a deterministic pattern. It compares read data, counts mismatches and timeouts, and reports completion to the top-level start/ready controls.

## Interface
Parameters:
- NUM_CH, 2: number of channels / bus masters driven
- ADDR_WIDTH, 16: bus address width
- DATA_WIDTH, 8: bus data width
- SLAVE_MEM_ADDR_WIDTH, 12: slave memory offset width; generated offsets wrap within it
- BURST_LEN, 4: beats per channel per operation (1..256)
- TIMEOUT, 64: max cycles waiting for read data before a beat is declared failed
- ERR_WIDTH, 8: width of error counter

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  operation request; honoured only when busy=0
- mode  in  2  00 write, 01 read-verify, 10 write-then-read-verify, 11 treated as 10
- ch_en  in  NUM_CH  channel enables, sampled with start
- slave_sel  in  ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH  upper address field, sampled with start
- seed  in  DATA_WIDTH  pattern base, sampled with start
- ch_ready  out  NUM_CH  channel idle
- busy  out  1  any channel active
- done  out  1  one-cycle pulse when operation completes
- err_count  out  ERR_WIDTH  saturating mismatch+timeout count of last operation
- d_valid  out  NUM_CH  per-channel request valid
- d_mode  out  NUM_CH  1 write, 0 read
- d_addr  out  NUM_CH*ADDR_WIDTH  request address, channel c at slice c
- d_wdata  out  NUM_CH*DATA_WIDTH  write data
- d_ready  in  NUM_CH  master accepts request
- d_rvalid  in  NUM_CH  one-cycle read-data strobe
- d_rdata  in  NUM_CH*DATA_WIDTH  read data

## Operation
- Reset values: ch_ready all 1, busy 0, done 0, err_count 0, d_valid 0, d_mode 0, d_addr 0, d_wdata 0.
- start with busy=0: latch mode, ch_en, slave_sel, seed; clear err_count; enabled channels leave IDLE. start while busy=1 is ignored.
- Beat b (0..BURST_LEN-1) on channel c:
  - offset = (c*BURST_LEN + b) mod 2^SLAVE_MEM_ADDR_WIDTH
  - addr = {slave_sel, offset}
  - data = (seed + c*16 + b) mod 2^DATA_WIDTH
- Channel FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, FIN.
  - IDLE: start moves to WR_REQ (mode 00/10) or RD_REQ (01).
  - WR_REQ: last write beat accepted moves to RD_REQ (mode 10) or FIN (mode 00).
  - RD_REQ: handshake moves to RD_WAIT.
  - RD_WAIT: rvalid or timeout moves to RD_REQ (next beat) or FIN after the last beat.
  - FIN: holds until all enabled channels reach FIN, then all return to IDLE together.
- Handshake: a transfer occurs when d_valid && d_ready at posedge. d_valid, d_mode, d_addr and d_wdata stay stable while d_valid=1 and d_ready=0.
- Read check: on d_rvalid in RD_WAIT, a mismatch between d_rdata and the expected pattern increments err_count. d_rvalid outside RD_WAIT is ignored.
- Timeout: a cycle counter starts at RD_WAIT entry. When it reaches TIMEOUT without rvalid, the beat is counted as an error and the channel moves on.
- err_count saturates at 2^ERR_WIDTH-1. Simultaneous errors from several channels in one cycle all add, with saturation.
- start with ch_en=0: done pulses the next cycle and busy stays 0.
- rstn low mid-operation: all state returns to reset values immediately, with no done pulse.

## Timing
- Cycle after the accepted start: d_valid of enabled channels high and busy high.
- Next beat request is presented the cycle after a handshake (d_valid may drop for zero cycles on back-to-back writes).
- Read request handshake: d_valid low in RD_WAIT. The next RD_REQ is asserted the cycle after rvalid.
- done pulses one cycle after the last enabled channel enters FIN. In the same cycle busy falls and ch_ready rises.
- err_count is final and stable when done is high.
- Minimum mode-00 latency with d_ready tied high: BURST_LEN+2 cycles from start to done.

## Structure
- Package demo_seq_pkg: mode encoding constants (MODE_WR, MODE_RD, MODE_WRV), channel state enum, pattern channel stride constant 16.
- Sub-module demo_seq_ch: one channel FSM, beat counter, timeout counter and pattern/address generation, emitting a per-cycle error pulse. It is instantiated NUM_CH times in a generate loop.
- Top level holds start latching, the FIN barrier, done generation and the saturating error adder.

## Test plan
- Reset then idle: all outputs at reset values, ch_ready all 1, and no d_valid for 20 cycles.
- mode=10, ch_en=01, seed=0x10, slave_sel=1, responsive memory model:
  - writes go to 0x1000..0x1003 with data 0x10..0x13, followed by matching reads
  - done pulses once, err_count=0
- mode=10, ch_en=11, d_ready randomly stalled:
  - channel 1 accesses offsets 4..7 with data seed+16+b
  - requests stay stable during stalls
  - done pulses after both channels finish, err_count=0
- Read-verify with corrupted beat 2 on channel 0, plus channel 1 never giving rvalid on beat 0:
  - err_count=2 (mismatch + timeout after TIMEOUT cycles)
  - done still pulses
- start while busy and start with ch_en=0:
  - the start while busy is ignored
  - the start with ch_en=0 gives a done one cycle later with busy never high
- rstn pulled low mid-burst: outputs return to reset values immediately, and a following start completes normally.
